// File: rtl/peri_pkg.sv
// Shared types and defaults for the peripheral write buffer.
package peri_pkg;

  localparam int PERI_AW    = 16;
  localparam int PERI_DW    = 16;
  localparam int PERI_DEPTH = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } wbuf_state_t;

  // count has to hold 0..DEPTH inclusive, so it needs one more code than the pointers
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PERI_CW = cnt_w(PERI_DEPTH);

endpackage

// File: rtl/peri_wbuf_fifo.sv
// Circular store queue with optional same-address merge into the tail entry.
module peri_wbuf_fifo
  import peri_pkg::*;
#(
  parameter int AW       = PERI_AW,
  parameter int DW       = PERI_DW,
  parameter int DEPTH    = PERI_DEPTH,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             wr_addr,
  input  logic [DW-1:0]             wr_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic [AW-1:0]             head_addr,
  output logic [DW-1:0]             head_data,
  output logic [AW-1:0]             next_addr,
  output logic [DW-1:0]             next_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head, tail, tail_last, head_succ, wr_ptr;
  logic          merge, alloc;
  logic [CW-1:0] count_next;

  assign tail_last  = tail - PW'(1);
  assign head_succ  = head + PW'(1);
  // With count>=2 the tail entry is never the presented head, so merging is safe
  assign merge      = MERGE_EN && push && (count >= CW'(2)) && (addr_mem[tail_last] == wr_addr);
  assign alloc      = push && !merge;
  assign wr_ptr     = merge ? tail_last : tail;
  assign count_next = count + CW'(alloc) - CW'(pop);

  // Read ports forward this cycle's write so the presenter never loads stale data
  assign head_addr = (push && wr_ptr == head)      ? wr_addr : addr_mem[head];
  assign head_data = (push && wr_ptr == head)      ? wr_data : data_mem[head];
  assign next_addr = (push && wr_ptr == head_succ) ? wr_addr : addr_mem[head_succ];
  assign next_data = (push && wr_ptr == head_succ) ? wr_data : data_mem[head_succ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      empty <= 1'b1;
    end else begin
      if (alloc) tail <= tail + PW'(1);
      if (pop)   head <= head_succ;
      count <= count_next;
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      addr_mem[wr_ptr] <= wr_addr;
      data_mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/peri_write_buffer.sv
// Store buffer between the pipeline store path and a ready-handshaked peripheral write bus.
module peri_write_buffer
  import peri_pkg::*;
#(
  parameter int AW       = PERI_AW,
  parameter int DW       = PERI_DW,
  parameter int DEPTH    = PERI_DEPTH,
  parameter bit MERGE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    boot_up,
  input  logic                    st_valid,
  input  logic [AW-1:0]           st_addr,
  input  logic [DW-1:0]           st_data,
  output logic                    st_stall,
  input  logic                    peri_ready,
  output logic                    peri_web,
  output logic [AW-1:0]           peri_addr,
  output logic [DW-1:0]           peri_datao,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    empty
);

  localparam int CW = cnt_w(DEPTH);

  wbuf_state_t   state, state_next;
  logic          push, pop, load_head, load_next;
  logic [AW-1:0] head_addr, next_addr;
  logic [DW-1:0] head_data, next_data;

  assign st_stall = boot_up || (count == CW'(DEPTH));
  assign push     = st_valid && !st_stall;
  assign pop      = !peri_web && peri_ready && !boot_up;

  peri_wbuf_fifo #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .MERGE_EN (MERGE_EN)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (boot_up),
    .push      (push),
    .pop       (pop),
    .wr_addr   (st_addr),
    .wr_data   (st_data),
    .count     (count),
    .empty     (empty),
    .head_addr (head_addr),
    .head_data (head_data),
    .next_addr (next_addr),
    .next_data (next_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // After a transfer the successor slot becomes the head, so it is loaded directly
  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_next  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0 || push) begin
          state_next = PRESENT;
          load_head  = 1'b1;
        end
      end
      PRESENT: begin
        if (pop) begin
          if (count >= CW'(2) || push) load_next  = 1'b1;
          else                         state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (boot_up) begin
      state_next = IDLE;
      load_head  = 1'b0;
      load_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peri_web   <= 1'b1;
      peri_addr  <= '0;
      peri_datao <= '0;
    end else begin
      peri_web <= (state_next == IDLE);
      if (load_head) begin
        peri_addr  <= head_addr;
        peri_datao <= head_data;
      end else if (load_next) begin
        peri_addr  <= next_addr;
        peri_datao <= next_data;
      end
    end
  end

endmodule

// File: tb/tb_peri_write_buffer.sv
// Vector table, corner sequences and random traffic checked against a queue model.
module tb_peri_write_buffer;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n, boot_up, st_valid, peri_ready;
  logic [AW-1:0] st_addr, peri_addr;
  logic [DW-1:0] st_data, peri_datao;
  logic          st_stall, peri_web, empty;
  logic [2:0]    count;

  peri_write_buffer #(
    .AW       (AW),
    .DW       (DW),
    .DEPTH    (DEPTH),
    .MERGE_EN (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .boot_up    (boot_up),
    .st_valid   (st_valid),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_stall   (st_stall),
    .peri_ready (peri_ready),
    .peri_web   (peri_web),
    .peri_addr  (peri_addr),
    .peri_datao (peri_datao),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  bit            m_pres;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          r;
    logic          b;
    logic          e_web;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            e_cnt;
    logic          e_stall;
  } vec_t;

  vec_t tbl[27];

  function automatic vec_t mk(logic v, logic [AW-1:0] a, logic [DW-1:0] d, logic r, logic b,
                              logic ew, logic [AW-1:0] ea, logic [DW-1:0] ed, int ec, logic es);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.r = r; t.b = b;
    t.e_web = ew; t.e_addr = ea; t.e_data = ed; t.e_cnt = ec; t.e_stall = es;
    return t;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_pres = 1'b0;
    m_addr = '0;
    m_data = '0;
  endfunction

  // Queue holds every occupied entry; element 0 is whatever the bus shows
  function automatic void model_step();
    bit   full, xfer, acc, mrg;
    ent_t e;
    if (boot_up) begin
      q.delete();
      m_pres = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    xfer = m_pres && peri_ready;
    acc  = st_valid && !full;
    mrg  = acc && q.size() >= 2 && q[q.size()-1].a == st_addr;
    if (xfer) void'(q.pop_front());
    if (acc) begin
      if (mrg) begin
        e = q[q.size()-1];
        e.d = st_data;
        q[q.size()-1] = e;
      end else begin
        e.a = st_addr;
        e.d = st_data;
        q.push_back(e);
      end
    end
    if (q.size() > 0) begin
      m_pres = 1'b1;
      m_addr = q[0].a;
      m_data = q[0].d;
    end else begin
      m_pres = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag);
    cmp({tag, ".web"},   32'(peri_web),   32'(!m_pres));
    cmp({tag, ".addr"},  32'(peri_addr),  32'(m_addr));
    cmp({tag, ".data"},  32'(peri_datao), 32'(m_data));
    cmp({tag, ".count"}, 32'(count),      32'(q.size()));
    cmp({tag, ".empty"}, 32'(empty),      32'(q.size() == 0));
    cmp({tag, ".stall"}, 32'(st_stall),   32'(boot_up || q.size() == DEPTH));
  endtask

  task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic r, input logic b);
    st_valid   = v;
    st_addr    = a;
    st_data    = d;
    peri_ready = r;
    boot_up    = b;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; boot_up = 1'b0; st_valid = 1'b0; peri_ready = 1'b0;
    st_addr = '0; st_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checkOutput("reset");
    rst_n = 1'b1;

    // single store, merge, merge guard, fill/drain, boot flush
    tbl[0]  = mk(1, 'h0010, 'hABCD, 1, 0,  0, 'h0010, 'hABCD, 1, 0);
    tbl[1]  = mk(0, 'h0000, 'h0000, 1, 0,  1, 'h0010, 'hABCD, 0, 0);
    tbl[2]  = mk(1, 'h0020, 'h1111, 0, 0,  0, 'h0020, 'h1111, 1, 0);
    tbl[3]  = mk(1, 'h0030, 'h2222, 0, 0,  0, 'h0020, 'h1111, 2, 0);
    tbl[4]  = mk(1, 'h0030, 'h3333, 0, 0,  0, 'h0020, 'h1111, 2, 0);
    tbl[5]  = mk(0, 'h0000, 'h0000, 1, 0,  0, 'h0030, 'h3333, 1, 0);
    tbl[6]  = mk(0, 'h0000, 'h0000, 1, 0,  1, 'h0030, 'h3333, 0, 0);
    tbl[7]  = mk(1, 'h0040, 'h5555, 0, 0,  0, 'h0040, 'h5555, 1, 0);
    tbl[8]  = mk(1, 'h0040, 'h6666, 0, 0,  0, 'h0040, 'h5555, 2, 0);
    tbl[9]  = mk(0, 'h0000, 'h0000, 1, 0,  0, 'h0040, 'h6666, 1, 0);
    tbl[10] = mk(0, 'h0000, 'h0000, 1, 0,  1, 'h0040, 'h6666, 0, 0);
    tbl[11] = mk(1, 'h0100, 'hA001, 0, 0,  0, 'h0100, 'hA001, 1, 0);
    tbl[12] = mk(1, 'h0200, 'hA002, 0, 0,  0, 'h0100, 'hA001, 2, 0);
    tbl[13] = mk(1, 'h0300, 'hA003, 0, 0,  0, 'h0100, 'hA001, 3, 0);
    tbl[14] = mk(1, 'h0400, 'hA004, 0, 0,  0, 'h0100, 'hA001, 4, 1);
    tbl[15] = mk(1, 'h0500, 'hA005, 0, 0,  0, 'h0100, 'hA001, 4, 1);
    tbl[16] = mk(0, 'h0000, 'h0000, 1, 0,  0, 'h0200, 'hA002, 3, 0);
    tbl[17] = mk(0, 'h0000, 'h0000, 1, 0,  0, 'h0300, 'hA003, 2, 0);
    tbl[18] = mk(0, 'h0000, 'h0000, 1, 0,  0, 'h0400, 'hA004, 1, 0);
    tbl[19] = mk(0, 'h0000, 'h0000, 1, 0,  1, 'h0400, 'hA004, 0, 0);
    tbl[20] = mk(1, 'h0060, 'h0001, 0, 0,  0, 'h0060, 'h0001, 1, 0);
    tbl[21] = mk(1, 'h0061, 'h0002, 0, 0,  0, 'h0060, 'h0001, 2, 0);
    tbl[22] = mk(1, 'h0062, 'h0003, 0, 0,  0, 'h0060, 'h0001, 3, 0);
    tbl[23] = mk(0, 'h0000, 'h0000, 1, 1,  1, 'h0060, 'h0001, 0, 1);
    tbl[24] = mk(1, 'h0070, 'h9999, 1, 1,  1, 'h0060, 'h0001, 0, 1);
    tbl[25] = mk(1, 'h0050, 'h7777, 1, 0,  0, 'h0050, 'h7777, 1, 0);
    tbl[26] = mk(0, 'h0000, 'h0000, 1, 0,  1, 'h0050, 'h7777, 0, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].r, tbl[i].b);
      cmp($sformatf("vec%0d.web", i),   32'(peri_web),   32'(tbl[i].e_web));
      cmp($sformatf("vec%0d.addr", i),  32'(peri_addr),  32'(tbl[i].e_addr));
      cmp($sformatf("vec%0d.data", i),  32'(peri_datao), 32'(tbl[i].e_data));
      cmp($sformatf("vec%0d.count", i), 32'(count),      32'(tbl[i].e_cnt));
      cmp($sformatf("vec%0d.stall", i), 32'(st_stall),   32'(tbl[i].e_stall));
      checkOutput($sformatf("vec%0d.model", i));
    end

    // streaming: one store per cycle with the peripheral always ready, across pointer wrap
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'h0A00 + 16'(i), 16'hC000 + 16'(i), 1'b1, 1'b0);
      checkOutput($sformatf("stream%0d", i));
      cmp($sformatf("stream%0d.cnt_le2", i), 32'(count <= 3'd2), 32'd1);
      cmp($sformatf("stream%0d.addr", i), 32'(peri_addr), 32'h0A00 + 32'(i));
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("stream_end");

    // asynchronous reset while a write is on the bus
    applyStimulus(1'b1, 16'h0080, 16'h8888, 1'b0, 1'b0);
    checkOutput("pre_rst");
    st_valid = 1'b0;
    peri_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp("async_rst.web",   32'(peri_web),   32'd1);
    cmp("async_rst.addr",  32'(peri_addr),  32'd0);
    cmp("async_rst.data",  32'(peri_datao), 32'd0);
    cmp("async_rst.count", 32'(count),      32'd0);
    cmp("async_rst.empty", 32'(empty),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkOutput("post_rst");

    // random traffic with a small address set so merges happen often
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), 16'($urandom_range(0, 3)), 16'($urandom),
                    ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 3));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
